// File: rtl/mux_nx1_hs_pkg.sv
// Shared definitions for the N-to-1 handshake multiplexer: selection mode encoding.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/mux_nx1_hs_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping past N-1 to 0.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [N-1:0] req_rot_s;
  int           off_s;
  int           sum_s;

  // Rotate so bit 0 is the requester at ptr; the doubled vector handles wrap.
  assign req_rot_s = N'({req, req} >> ptr);

  // Lowest set bit of the rotated vector is the winner; map back to a channel index.
  always_comb begin
    gnt_valid = 1'b0;
    off_s     = 0;
    sum_s     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot_s[k]) begin
        gnt_valid = 1'b1;
        off_s     = k;
      end else begin
        off_s     = off_s;
      end
    end
    sum_s = int'(ptr) + off_s;
    if (sum_s >= N) begin
      sum_s = sum_s - N;
    end else begin
      sum_s = sum_s;
    end
    gnt_idx = SEL_W'(sum_s);
  end

endmodule

// File: rtl/mux_nx1_hs.sv
// N-to-1 multiplexer with valid/ready on every channel and a 1-entry registered output;
// fixed-select or round-robin channel choice.
module mux_nx1_hs
  import mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [N*W-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_ch,
  output logic             sel_err
);

  mode_e            mode_s;
  logic             ld_s;
  logic             fix_valid_s;
  logic             arb_valid_s;
  logic [SEL_W-1:0] arb_idx_s;
  logic             grant_valid_s;
  logic [SEL_W-1:0] grant_s;
  logic [W-1:0]     grant_data_s;
  logic             xfer_s;
  logic             err_s;
  logic [SEL_W-1:0] ptr_r;

  assign mode_s      = mode_e'(mode);
  assign ld_s        = !out_valid || out_ready;
  assign fix_valid_s = int'(sel) < N;

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .ptr       (ptr_r),
    .gnt_valid (arb_valid_s),
    .gnt_idx   (arb_idx_s)
  );

  // Pick the grant source for the current mode.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = '0;
    case (mode_s)
      MODE_FIXED: begin
        grant_valid_s = fix_valid_s;
        grant_s       = sel;
      end
      MODE_RR: begin
        grant_valid_s = arb_valid_s;
        grant_s       = arb_idx_s;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_s       = '0;
      end
    endcase
  end

  // Ready goes to the granted channel only; reset suppresses all handshakes.
  always_comb begin
    in_ready = '0;
    if (!rst && ld_s && grant_valid_s) begin
      in_ready[grant_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  assign xfer_s       = |(in_ready & in_valid);
  assign grant_data_s = in_data[int'(grant_s)*W +: W];
  assign err_s        = (mode_s == MODE_FIXED) && !fix_valid_s && (|in_valid);

  // Output register, rr pointer and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr_r     <= '0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= err_s;
      if (xfer_s) begin
        out_valid <= 1'b1;
        out_data  <= grant_data_s;
        out_ch    <= grant_s;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer_s && (mode_s == MODE_RR)) begin
        ptr_r <= (grant_s == SEL_W'(N - 1)) ? '0 : grant_s + SEL_W'(1);
      end
    end
  end

endmodule
